// File: rtl/taxi_pkg.sv
// Shared widths, limits and helpers for the taxi meter BCD datapath.
package taxi_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned FARE_IN_W  = 12;
    localparam int unsigned BCD_OUT_W  = 16;
    localparam int unsigned NUM_DIGITS = BCD_OUT_W / DIGIT_W;

    localparam logic [BCD_OUT_W-1:0] BCD_MAX_4D = 16'h9999;

    // Elaboration-time conversion so run-time comparisons stay in the BCD domain.
    function automatic logic [BCD_OUT_W-1:0] bin_to_bcd4(input int unsigned value);
        logic [BCD_OUT_W-1:0] result;
        int unsigned          rem;
        result = '0;
        rem    = value;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            result[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(rem % 10);
            rem = rem / 10;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_add4.sv
// Combinational 4-digit packed-BCD adder with decimal carry-out.
module bcd_add4
    import taxi_pkg::*;
(
    input  logic [BCD_OUT_W-1:0] a,
    input  logic [BCD_OUT_W-1:0] b,
    output logic [BCD_OUT_W-1:0] sum,
    output logic                 cout
);

    logic [DIGIT_W:0] digit;
    logic             carry;

    always_comb begin
        sum   = '0;
        digit = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            digit = {1'b0, a[i*DIGIT_W +: DIGIT_W]} + {1'b0, b[i*DIGIT_W +: DIGIT_W]}
                  + {{DIGIT_W{1'b0}}, carry};
            // Adding 6 to a digit above 9 skips the six unused codes and sets bit 4.
            if (digit > 5'd9) begin
                digit = digit + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[i*DIGIT_W +: DIGIT_W] = digit[DIGIT_W-1:0];
        end
        cout = carry;
    end

endmodule

// File: rtl/distance_fare.sv
// Distance/fare BCD accumulator clocked by the 10 m odometer pulse.
// Optional registered saturation flag: define DISTANCE_FARE_FULL_FLAG_EN.
module distance_fare
    import taxi_pkg::*;
#(
    parameter int unsigned BASE_PULSES = 0
) (
    input  logic                 ten_meter_pulse,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [FARE_IN_W-1:0] distance_fare_per_pulse,
    input  logic [FARE_IN_W-1:0] s_fare,
    output logic [BCD_OUT_W-1:0] distance_bcd,
    output logic [BCD_OUT_W-1:0] distance_fare_bcd
`ifdef DISTANCE_FARE_FULL_FLAG_EN
    ,
    output logic                 full
`endif
);

    localparam logic [BCD_OUT_W-1:0] BASE_BCD = bin_to_bcd4(BASE_PULSES);

    logic [BCD_OUT_W-1:0] dist_sum;
    logic                 dist_cout;
    logic [BCD_OUT_W-1:0] fare_sum;
    logic                 fare_cout;
    logic                 step;
    logic                 charge;
    logic [BCD_OUT_W-1:0] fare_next;

    bcd_add4 u_dist_add (
        .a    (distance_bcd),
        .b    (16'h0001),
        .sum  (dist_sum),
        .cout (dist_cout)
    );

    bcd_add4 u_fare_add (
        .a    (distance_fare_bcd),
        .b    ({4'h0, distance_fare_per_pulse}),
        .sum  (fare_sum),
        .cout (fare_cout)
    );

    // Carry out of the +1 only happens at 9999, so it doubles as the stop condition.
    // Packed BCD orders like the decimal value, so >= works digit-agnostic.
    always_comb begin
        step      = en && !dist_cout;
        charge    = distance_bcd >= BASE_BCD;
        fare_next = fare_cout ? BCD_MAX_4D : fare_sum;
    end

    always_ff @(posedge ten_meter_pulse) begin
        if (!rst_n) begin
            distance_bcd      <= '0;
            distance_fare_bcd <= {4'h0, s_fare};
        end else if (step) begin
            distance_bcd <= dist_sum;
            if (charge) begin
                distance_fare_bcd <= fare_next;
            end
        end
    end

`ifdef DISTANCE_FARE_FULL_FLAG_EN
    always_ff @(posedge ten_meter_pulse) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (step && (dist_sum == BCD_MAX_4D || (charge && fare_next == BCD_MAX_4D))) begin
            full <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_distance_fare.sv
// Scoreboard bench for distance_fare; two instances (BASE_PULSES 0 and 300) share stimulus.
module tb_distance_fare;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] per;
    logic [11:0] sfare;
    logic [15:0] d0, f0, d1, f1;
    logic        full0, full1;

    distance_fare #(.BASE_PULSES(0)) dut0 (
        .ten_meter_pulse         (clk),
        .rst_n                   (rst_n),
        .en                      (en),
        .distance_fare_per_pulse (per),
        .s_fare                  (sfare),
        .distance_bcd            (d0),
        .distance_fare_bcd       (f0)
`ifdef DISTANCE_FARE_FULL_FLAG_EN
        ,
        .full                    (full0)
`endif
    );

    distance_fare #(.BASE_PULSES(300)) dut1 (
        .ten_meter_pulse         (clk),
        .rst_n                   (rst_n),
        .en                      (en),
        .distance_fare_per_pulse (per),
        .s_fare                  (sfare),
        .distance_bcd            (d1),
        .distance_fare_bcd       (f1)
`ifdef DISTANCE_FARE_FULL_FLAG_EN
        ,
        .full                    (full1)
`endif
    );

`ifndef DISTANCE_FARE_FULL_FLAG_EN
    assign full0 = 1'b0;
    assign full1 = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] d0, f0, d1, f1;
        logic        full0, full1;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Reference model: plain decimal integers per instance.
    int m_dist[2];
    int m_fare[2];
    bit m_full[2];
    int m_base[2] = '{0, 300};

    logic [11:0] cur_sf;
    logic [11:0] cur_pp;

    function automatic int bcd2int(input logic [15:0] v);
        return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic logic [11:0] rand_bcd3();
        logic [11:0] r;
        r[3:0]  = 4'($urandom_range(0, 9));
        r[7:4]  = 4'($urandom_range(0, 9));
        r[11:8] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    function automatic void model_edge(input logic e, input logic r, input logic [11:0] sf, input logic [11:0] pp);
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                m_dist[k] = 0;
                m_fare[k] = bcd2int({4'h0, sf});
                m_full[k] = 1'b0;
            end else if (e && m_dist[k] < 9999) begin
                if (m_dist[k] >= m_base[k]) begin
                    m_fare[k] = m_fare[k] + bcd2int({4'h0, pp});
                    if (m_fare[k] >= 9999) begin
                        m_fare[k] = 9999;
                        m_full[k] = 1'b1;
                    end
                end
                m_dist[k] = m_dist[k] + 1;
                if (m_dist[k] == 9999) m_full[k] = 1'b1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic e, input logic r);
        exp_t x;
        #1;
        en    = e;
        rst_n = r;
        sfare = cur_sf;
        per   = cur_pp;
        @(posedge clk);
        model_edge(e, r, cur_sf, cur_pp);
        x.d0    = int2bcd(m_dist[0]);
        x.f0    = int2bcd(m_fare[0]);
        x.d1    = int2bcd(m_dist[1]);
        x.f1    = int2bcd(m_fare[1]);
`ifdef DISTANCE_FARE_FULL_FLAG_EN
        x.full0 = m_full[0];
        x.full1 = m_full[1];
`else
        x.full0 = 1'b0;
        x.full1 = 1'b0;
`endif
        sb.push_back(x);
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) step(e, 1'b1);
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the update edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("sb_dist0", d0, x.d0);
                check("sb_fare0", f0, x.f0);
                check("sb_dist1", d1, x.d1);
                check("sb_fare1", f1, x.f1);
`ifdef DISTANCE_FARE_FULL_FLAG_EN
                check("sb_full0", {15'd0, full0}, {15'd0, x.full0});
                check("sb_full1", {15'd0, full1}, {15'd0, x.full1});
`endif
            end
        end
    end

    initial begin
        rst_n  = 1'b1;
        en     = 1'b0;
        cur_sf = 12'h300;
        cur_pp = 12'h003;
        sfare  = cur_sf;
        per    = cur_pp;

        step(1'b1, 1'b0);
        #1;
        check("reset_dist", d0, 16'h0000);
        check("reset_fare", f0, 16'h0300);

        run(5, 1'b0);
        #1;
        check("hold_dist", d0, 16'h0000);
        check("hold_fare", f0, 16'h0300);

        cur_sf = 12'h555;
        run(120, 1'b1);
        #1;
        check("acc_dist", d0, 16'h0120);
        check("acc_fare", f0, 16'h0660);
        check("acc_base_fare", f1, 16'h0300);

        cur_sf = 12'h300;
        cur_pp = 12'h020;
        step(1'b0, 1'b0);
        run(305, 1'b1);
        #1;
        check("base_dist", d1, 16'h0305);
        check("base_fare", f1, 16'h0400);

        cur_sf = 12'h999;
        cur_pp = 12'h999;
        step(1'b0, 1'b0);
        run(12, 1'b1);
        #1;
        check("clamp_fare", f0, 16'h9999);
        check("clamp_dist", d0, 16'h0012);
`ifdef DISTANCE_FARE_FULL_FLAG_EN
        check("clamp_full", {15'd0, full0}, 16'h0001);
`endif

        cur_sf = 12'h300;
        cur_pp = 12'h001;
        step(1'b0, 1'b0);
        run(9999, 1'b1);
        #1;
        check("stop_dist", d0, 16'h9999);
        check("stop_fare1", f1, 16'h9999);
        run(3, 1'b1);
        #1;
        check("stop_dist_hold", d0, 16'h9999);
        check("stop_fare_hold", f0, 16'h9999);

        cur_pp = 12'h012;
        step(1'b0, 1'b0);
        run(50, 1'b1);
        step(1'b1, 1'b0);
        #1;
        check("midrst_dist", d0, 16'h0000);
        check("midrst_fare", f0, 16'h0300);
`ifdef DISTANCE_FARE_FULL_FLAG_EN
        check("midrst_full", {15'd0, full0}, 16'h0000);
`endif

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) cur_pp = rand_bcd3();
            cur_sf = rand_bcd3();
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (sb.size() == 0) pass_cnt++;
        else $display("FAIL drain queued=%0d required=0", sb.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
